// File: rtl/id_hazard_scheduler.sv
// id_hazard_scheduler: decode-stage hazard scheduler.
// Keeps a two-entry scoreboard (EX, MEM) of in-flight instructions and
// derives the ID stall, the branch-compare forwarding selects and the
// IF/ID flush from it and from the current ID-stage fields.
// Optional feature macro: HAZARD_STATS_EN adds saturating stall/flush counters.
module id_hazard_scheduler #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             idValid,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             idUsesRs,
  input  logic             idUsesRt,
  input  logic             idBranch,
  input  logic             idRegWrite,
  input  logic             idMemRead,
  input  logic [REG_W-1:0] idDestReg,
  input  logic             PCSrc,
  input  logic             Jump,
  input  logic             freeze,
  output logic             stall,
  output logic             ForwardAD,
  output logic             ForwardBD,
`ifdef HAZARD_STATS_EN
  output logic [31:0]      stallCount,
  output logic [31:0]      flushCount,
`endif
  output logic             flushIFID
);

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_read;
    logic [REG_W-1:0] dest;
  } sb_entry_t;

  sb_entry_t ex_q, ex_d;
  sb_entry_t mem_q, mem_d;

  logic rs_rel, rt_rel;
  logic hazard_rs, hazard_rt;

  // An entry matches a source when it is live and targets that register.
  function automatic logic hit(input sb_entry_t e, input logic [REG_W-1:0] src);
    return e.valid && (e.dest == src);
  endfunction

  // A source taking part in a branch compare or an ALU op can be blocked by
  // a load still in EX, an ALU result still in EX (compare only) or a load
  // in MEM (compare only); later results arrive via register-file write-through.
  function automatic logic src_hazard(input sb_entry_t ex, input sb_entry_t mem,
                                      input logic [REG_W-1:0] src, input logic br);
    return (hit(ex, src) && ex.mem_read) ||
           (br && hit(ex, src) && ex.reg_write) ||
           (br && hit(mem, src) && mem.mem_read);
  endfunction

  // Hazard detection and forwarding selects, purely from scoreboard + ID fields.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    rs_rel    = idUsesRs && (rs != '0);
    rt_rel    = idUsesRt && (rt != '0);
    hazard_rs = rs_rel && src_hazard(ex_q, mem_q, rs, idBranch);
    hazard_rt = rt_rel && src_hazard(ex_q, mem_q, rt, idBranch);

    stall     = freeze || (idValid && (hazard_rs || hazard_rt));

    ForwardAD = idBranch && rs_rel && hit(mem_q, rs) && mem_q.reg_write && !mem_q.mem_read;
    ForwardBD = idBranch && rt_rel && hit(mem_q, rt) && mem_q.reg_write && !mem_q.mem_read;

    // A redirect is only honoured once the branch/jump is allowed to leave ID.
    flushIFID = idValid && (PCSrc || Jump) && !stall;
  end

  // Scoreboard next state: advance unless frozen; a stall injects a bubble into EX.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    if (!freeze) begin
      mem_d           = ex_q;
      ex_d.valid      = idValid && !stall;
      ex_d.reg_write  = idRegWrite;
      ex_d.mem_read   = idMemRead;
      ex_d.dest       = idDestReg;
    end
  end

  // Scoreboard registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters: hazard stalls (not freezes) and IF/ID flushes.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !freeze && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flushIFID && (flush_cnt_q != '1))        flush_cnt_d = flush_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stallCount = stall_cnt_q;
  assign flushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_hazard_scheduler.sv
// Directed testbench for id_hazard_scheduler. Inputs change 1 ns after a
// rising edge; outputs are compared 1 ns after the inputs settle.
module tb_id_hazard_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       idValid, idUsesRs, idUsesRt, idBranch, idRegWrite, idMemRead;
  logic [4:0] rs, rt, idDestReg;
  logic       PCSrc, Jump, freeze;
  logic       stall, ForwardAD, ForwardBD, flushIFID;
`ifdef HAZARD_STATS_EN
  logic [31:0] stallCount, flushCount;
`endif

  int n_asserts = 0;
  int n_fail    = 0;

  id_hazard_scheduler #(.REG_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .idValid    (idValid),
    .rs         (rs),
    .rt         (rt),
    .idUsesRs   (idUsesRs),
    .idUsesRt   (idUsesRt),
    .idBranch   (idBranch),
    .idRegWrite (idRegWrite),
    .idMemRead  (idMemRead),
    .idDestReg  (idDestReg),
    .PCSrc      (PCSrc),
    .Jump       (Jump),
    .freeze     (freeze),
    .stall      (stall),
    .ForwardAD  (ForwardAD),
    .ForwardBD  (ForwardBD),
`ifdef HAZARD_STATS_EN
    .stallCount (stallCount),
    .flushCount (flushCount),
`endif
    .flushIFID  (flushIFID)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive the ID-stage fields and let the combinational outputs settle.
  task automatic id(input logic v, input logic [4:0] r_s, input logic [4:0] r_t,
                    input logic ur, input logic ut, input logic br,
                    input logic rw, input logic mr, input logic [4:0] d,
                    input logic pc, input logic jp);
    idValid = v; rs = r_s; rt = r_t; idUsesRs = ur; idUsesRt = ut;
    idBranch = br; idRegWrite = rw; idMemRead = mr; idDestReg = d;
    PCSrc = pc; Jump = jp;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input logic s, input logic fa,
                      input logic fb, input logic fl);
    chk({tag, ".stall"}, 32'(stall), 32'(s));
    chk({tag, ".fwdA"},  32'(ForwardAD), 32'(fa));
    chk({tag, ".fwdB"},  32'(ForwardBD), 32'(fb));
    chk({tag, ".flush"}, 32'(flushIFID), 32'(fl));
  endtask

  initial begin
    // ---- Reset state ----
    rst_n = 1'b0; freeze = 1'b0;
    id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #10;
    chk3("reset", 0, 0, 0, 0);
`ifdef HAZARD_STATS_EN
    chk("reset.stallCount", stallCount, 0);
    chk("reset.flushCount", flushCount, 0);
`endif
    rst_n = 1'b1;

    // ---- Load-use: lw $3 then add rs=3 ----
    tick();
    id(1, 1, 0, 1, 0, 0, 1, 1, 3, 0, 0);          // lw $3, 0($1)
    chk("lu.lw", 32'(stall), 0);
    tick();
    id(1, 3, 4, 1, 1, 0, 1, 0, 6, 0, 0);          // add $6,$3,$4
    chk3("lu.hit", 1, 0, 0, 0);
    tick();                                       // EX now a bubble
    chk3("lu.issue", 0, 0, 0, 0);
    tick();
    id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ---- Branch after ALU op: add $5 then beq rs=5, taken ----
    id(1, 1, 2, 1, 1, 0, 1, 0, 5, 0, 0);          // add $5
    tick();
    id(1, 5, 0, 1, 1, 1, 0, 0, 0, 1, 0);          // beq $5,$0 taken
    chk3("bralu.stall", 1, 0, 0, 0);
    tick();                                       // MEM = add $5
    chk3("bralu.fwd", 0, 1, 0, 1);
    tick();
    id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // ---- Branch after load: lw $7 then beq rt=7 -> 2 stalls ----
    id(1, 1, 0, 1, 0, 0, 1, 1, 7, 0, 0);          // lw $7
    tick();
    id(1, 1, 7, 1, 1, 1, 0, 0, 0, 0, 0);          // beq $1,$7 not taken
    chk3("brld.c1", 1, 0, 0, 0);
    tick();
    chk3("brld.c2", 1, 0, 0, 0);
    tick();
    chk3("brld.c3", 0, 0, 0, 0);
    id(1, 1, 7, 1, 1, 1, 0, 0, 0, 0, 1);          // same slot, jump asserted
    chk("brld.jump", 32'(flushIFID), 1);
    tick();
    id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // ---- Register zero never matches ----
    id(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0);          // lw $0
    tick();
    id(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);          // beq on $0 vs EX load
    chk("r0.ld", 32'(stall), 0);
    tick();
    id(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0);          // add $0
    tick();
    id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();                                       // MEM = add $0
    id(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);          // beq $0,$0
    chk3("r0.alu", 0, 0, 0, 0);
    tick();
    id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // ---- Freeze with lw $2 in EX and add $9 in MEM ----
    id(1, 1, 0, 1, 0, 0, 1, 0, 9, 0, 0);          // add $9
    tick();
    id(1, 1, 0, 1, 0, 0, 1, 1, 2, 0, 0);          // lw $2
    tick();
    freeze = 1'b1;
    id(1, 9, 2, 1, 1, 1, 0, 0, 0, 1, 0);          // beq $9,$2 taken
    for (int i = 0; i < 3; i++) begin
      chk3($sformatf("frz.%0d", i), 1, 1, 0, 0);
      tick();
    end
    freeze = 1'b0;
    #1;
    chk3("frz.rel", 1, 1, 0, 0);                  // EX still lw $2, MEM still add $9
    tick();
    chk3("frz.memld", 1, 0, 0, 0);                // MEM = lw $2
    tick();
    chk3("frz.go", 0, 0, 0, 1);
    tick();
    id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ---- Async reset during a load-use stall ----
    id(1, 1, 0, 1, 0, 0, 1, 1, 4, 0, 0);          // lw $4
    tick();
    id(1, 4, 0, 1, 0, 0, 1, 0, 6, 0, 0);          // add $6,$4
    chk("rst.pre", 32'(stall), 1);
    rst_n = 1'b0;
    #1;
    chk("rst.drop", 32'(stall), 0);
`ifdef HAZARD_STATS_EN
    chk("rst.stallCount", stallCount, 0);
    chk("rst.flushCount", flushCount, 0);
`endif
    freeze = 1'b1;
    #1;
    chk("rst.freeze", 32'(stall), 1);
    freeze = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst.rel", 32'(stall), 0);
    tick();                                       // EX = add $6 from ID inputs
    id(1, 6, 0, 1, 0, 1, 0, 0, 0, 0, 0);          // beq $6
    chk("rst.exload", 32'(stall), 1);
    tick();
`ifdef HAZARD_STATS_EN
    chk("rst.count1", stallCount, 1);
`endif
    chk3("rst.fwd", 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
